// File: rtl/mem_readback_reader_pkg.sv
// Shared constants for the memory loader / readback pair and the readback FSM encoding.
package mem_readback_reader_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_readback_reader.sv
// Walks a block of memory_ip addresses and streams the words out over valid/ready,
// one outstanding read at a time so the memory port is only driven while in READ.
module mem_readback_reader
    import mem_readback_reader_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0]        WAIT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_remaining;
    logic [1:0]          r_wait_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_rden;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    // r_mem_addr doubles as the address counter; it only moves when a new READ is entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_wait_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_rden  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (word_count != '0) begin
                            r_mem_addr  <= base_addr;
                            r_remaining <= word_count;
                            r_mem_rden  <= 1'b1;
                            r_state     <= ST_READ;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_READ: begin
                    r_mem_rden <= 1'b0;
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_out_data  <= mem_q;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_PRESENT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                ST_PRESENT: begin
                    // Word is held until the sink takes it; no read-ahead.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_remaining <= r_remaining - CNT_ONE;
                        if (r_remaining == CNT_ONE) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_mem_addr <= r_mem_addr + ADDR_ONE;
                            r_mem_rden <= 1'b1;
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rden  = r_mem_rden;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_mem_readback_reader.sv
// Directed bench for mem_readback_reader: two instances (read latency 1 and 2) on one shared memory.
module tb_mem_readback_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        out_ready = 1'b0;
    logic        a_start = 1'b0;
    logic        b_start = 1'b0;
    logic [8:0]  base_addr = '0;
    logic [9:0]  word_count = '0;

    logic [8:0]  a_mem_addr, b_mem_addr;
    logic        a_mem_rden, b_mem_rden;
    logic [15:0] a_q, b_q, b_q1;
    logic [15:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid;
    logic        a_busy, b_busy, a_done, b_done;

    logic [15:0] mem [0:511];

    // memory_ip behaviour: latency 1 and latency 2 read ports onto the same array
    always @(posedge clk) if (a_mem_rden) a_q <= mem[a_mem_addr];
    always @(posedge clk) begin
        if (b_mem_rden) b_q1 <= mem[b_mem_addr];
        b_q <= b_q1;
    end

    mem_readback_reader #(.DATA_W(16), .ADDR_W(9), .READ_LATENCY(1)) u_dut_a (
        .clock(clk), .reset(reset), .start(a_start), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(a_mem_addr), .mem_rden(a_mem_rden),
        .mem_q(a_q), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .busy(a_busy), .done(a_done)
    );

    mem_readback_reader #(.DATA_W(16), .ADDR_W(9), .READ_LATENCY(2)) u_dut_b (
        .clock(clk), .reset(reset), .start(b_start), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(b_mem_addr), .mem_rden(b_mem_rden),
        .mem_q(b_q), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .busy(b_busy), .done(b_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    // Transaction-level model: a run of n words from base means the k-th read goes to
    // (base+k) mod 512 and the k-th beat carries mem[(base+k) mod 512].
    bit          act [2];
    logic [8:0]  m_base [2];
    int          m_cnt [2];
    int          rd_n [2];
    int          bt_n [2];
    int          done_n [2];
    int          e0 [2];
    int          fv_cyc [2];
    int          dn_cyc [2];
    bit          lv [2];
    bit          lacc [2];
    logic [15:0] ld [2];
    logic [8:0]  rd_log [2][16];
    logic [15:0] bt_log [2][16];

    task automatic mon(input int d, input logic rden, input logic [8:0] addr, input logic valid,
                       input logic [15:0] data, input logic ready, input logic dn);
        logic [8:0] ea;
        if (!act[d]) begin
            chk("idle_quiet", {29'd0, rden, valid, dn}, 32'd0);
            lv[d] = 1'b0;
            return;
        end
        if (rden) begin
            chk("rd_extra", {31'd0, rd_n[d] < m_cnt[d]}, 32'd1);
            chk("rd_ahead", rd_n[d], bt_n[d]);
            ea = m_base[d] + rd_n[d][8:0];
            chk("rd_addr", {23'd0, addr}, {23'd0, ea});
            if (rd_n[d] < 16) rd_log[d][rd_n[d]] = addr;
            rd_n[d]++;
        end
        if (lv[d] && !lacc[d]) begin
            chk("valid_hold", {31'd0, valid}, 32'd1);
            if (valid) chk("data_hold", {16'd0, data}, {16'd0, ld[d]});
        end
        if (valid) begin
            chk("beat_extra", {31'd0, bt_n[d] < m_cnt[d]}, 32'd1);
            ea = m_base[d] + bt_n[d][8:0];
            chk("beat_data", {16'd0, data}, {16'd0, mem[ea]});
            if (fv_cyc[d] < 0) fv_cyc[d] = cyc;
            if (ready) begin
                if (bt_n[d] < 16) bt_log[d][bt_n[d]] = data;
                bt_n[d]++;
            end
        end
        lv[d]   = valid;
        lacc[d] = valid && ready;
        ld[d]   = data;
        if (dn) begin
            chk("done_early", bt_n[d], m_cnt[d]);
            done_n[d]++;
            dn_cyc[d] = cyc;
            act[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            lv[0] = 1'b0;
            lv[1] = 1'b0;
        end else begin
            mon(0, a_mem_rden, a_mem_addr, a_out_valid, a_out_data, out_ready, a_done);
            mon(1, b_mem_rden, b_mem_addr, b_out_valid, b_out_data, out_ready, b_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int d, input logic [8:0] b, input int n);
        base_addr  = b;
        word_count = n[9:0];
        m_base[d]  = b;
        m_cnt[d]   = n;
        rd_n[d]    = 0;
        bt_n[d]    = 0;
        done_n[d]  = 0;
        fv_cyc[d]  = -1;
        dn_cyc[d]  = -1;
        lv[d]      = 1'b0;
        e0[d]      = cyc + 1;
        act[d]     = 1'b1;
        if (d == 0) a_start = 1'b1; else b_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_done(input int d, input string nm);
        int k = 0;
        while (done_n[d] == 0 && k < 80) begin
            tick();
            k++;
        end
        chk({nm, "_done_seen"}, {31'd0, done_n[d] != 0}, 32'd1);
        repeat (3) tick();
        chk({nm, "_done_once"}, done_n[d], 1);
    endtask

    task automatic wait_beat2(input string nm);
        int k = 0;
        while (!(bt_n[0] == 1 && a_out_valid) && k < 40) begin
            tick();
            k++;
        end
        chk({nm, "_beat2_found"}, {31'd0, k < 40}, 32'd1);
    endtask

    logic [15:0] exp_basic [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    logic [8:0]  exp_baddr [4] = '{9'd5, 9'd6, 9'd7, 9'd8};
    logic [15:0] exp_wrap  [4] = '{16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678};
    logic [8:0]  exp_waddr [4] = '{9'd510, 9'd511, 9'd0, 9'd1};

    task automatic check_block(input int d, input string nm, input bit wrap);
        chk({nm, "_beats"}, bt_n[d], 4);
        chk({nm, "_reads"}, rd_n[d], 4);
        for (int k = 0; k < 4; k++) begin
            chk({nm, "_data"}, {16'd0, bt_log[d][k]}, {16'd0, wrap ? exp_wrap[k] : exp_basic[k]});
            chk({nm, "_addr"}, {23'd0, rd_log[d][k]}, {23'd0, wrap ? exp_waddr[k] : exp_baddr[k]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 37 + 256);
        mem[5]   = 16'h0011;
        mem[6]   = 16'h0022;
        mem[7]   = 16'h0033;
        mem[8]   = 16'h0044;
        mem[510] = 16'hBEEF;
        mem[511] = 16'hCAFE;
        mem[0]   = 16'h1234;
        mem[1]   = 16'h5678;

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_a", {3'd0, a_mem_addr, a_mem_rden, a_out_data, a_out_valid, a_busy, a_done}, 32'd0);
        chk("rst_b", {3'd0, b_mem_addr, b_mem_rden, b_out_data, b_out_valid, b_busy, b_done}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // basic read, ready held high
        out_ready = 1'b1;
        start_run(0, 9'd5, 4);
        wait_done(0, "basic");
        check_block(0, "basic", 1'b0);
        chk("basic_first_valid", fv_cyc[0] - e0[0], 2);
        chk("basic_done_cycle", dn_cyc[0] - e0[0], 13);
        $display("basic read: beats=%0d reads=%0d", bt_n[0], rd_n[0]);

        // backpressure on beat 2
        start_run(0, 9'd5, 4);
        wait_beat2("bp");
        out_ready = 1'b0;
        repeat (7) begin
            chk("stall_valid", {31'd0, a_out_valid}, 32'd1);
            chk("stall_data", {16'd0, a_out_data}, 32'h0022);
            tick();
        end
        out_ready = 1'b1;
        wait_done(0, "bp");
        check_block(0, "bp", 1'b0);
        chk("bp_done_cycle", dn_cyc[0] - e0[0], 20);
        $display("backpressure: beats=%0d reads=%0d", bt_n[0], rd_n[0]);

        // wrap-around
        start_run(0, 9'd510, 4);
        wait_done(0, "wrap");
        check_block(0, "wrap", 1'b1);
        $display("wrap-around: beats=%0d reads=%0d", bt_n[0], rd_n[0]);

        // zero count
        start_run(0, 9'd33, 0);
        busy_n = 0;
        repeat (4) begin
            busy_n += int'(a_busy);
            tick();
        end
        chk("zero_busy_cycles", busy_n, 1);
        chk("zero_done", done_n[0], 1);
        chk("zero_reads", rd_n[0], 0);
        chk("zero_beats", bt_n[0], 0);
        chk("zero_done_cycle", dn_cyc[0] - e0[0], 1);
        $display("zero count: busy_cycles=%0d done=%0d", busy_n, done_n[0]);

        // reset while presenting word 2 of 4
        start_run(0, 9'd5, 4);
        wait_beat2("mid");
        out_ready = 1'b0;
        reset = 1'b1;
        act[0] = 1'b0;
        tick();
        chk("mid_rst_outputs", {3'd0, a_mem_addr, a_mem_rden, a_out_data, a_out_valid, a_busy, a_done}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        start_run(0, 9'd0, 1);
        wait_done(0, "after_rst");
        chk("after_rst_beats", bt_n[0], 1);
        chk("after_rst_data", {16'd0, bt_log[0][0]}, 32'h1234);
        $display("reset mid-run: restart beats=%0d data=%0h", bt_n[0], bt_log[0][0]);

        // start while busy is ignored
        start_run(0, 9'd5, 4);
        repeat (4) tick();
        base_addr  = 9'd100;
        word_count = 10'd2;
        a_start    = 1'b1;
        tick();
        a_start    = 1'b0;
        wait_done(0, "ign");
        check_block(0, "ign", 1'b0);
        chk("ign_done_cycle", dn_cyc[0] - e0[0], 13);
        $display("ignored start: beats=%0d reads=%0d", bt_n[0], rd_n[0]);

        // read latency 2 instance
        start_run(1, 9'd5, 4);
        wait_done(1, "lat2");
        check_block(1, "lat2", 1'b0);
        chk("lat2_first_valid", fv_cyc[1] - e0[1], 3);
        chk("lat2_done_cycle", dn_cyc[1] - e0[1], 17);
        $display("latency 2: beats=%0d reads=%0d", bt_n[1], rd_n[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_readback_reader.md
Name: mem_readback_reader

Overview:
- Reads a contiguous block of words back out of a memory_ip instance (data or instruction RAM) and streams them to a consumer over a valid/ready interface.
- It is the read-side counterpart of the file-driven memory loader: the loader writes words in, and this block walks addresses and reads them out for result dumping and load verification.
- Sits between a memory_ip port (address/rden/q) and a host-side sink such as a bench monitor or UART transmitter.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 9, memory address width; the address counter wraps modulo 2^ADDR_W.
- READ_LATENCY, 1, cycles from the clock edge that samples mem_addr/mem_rden to valid mem_q; legal values are 1 or 2.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a readback; ignored while busy.
- base_addr  in  ADDR_W  first address, latched on an accepted start.
- word_count  in  ADDR_W+1  number of words to read, latched on an accepted start; 0 is legal.
- mem_addr  out  ADDR_W  address to memory_ip.
- mem_rden  out  1  read enable to memory_ip.
- mem_q  in  DATA_W  memory_ip read data.
- out_data  out  DATA_W  streamed word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a readback completes.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; the ports are named clock and reset.
- Reset values: state=IDLE, mem_addr=0, mem_rden=0, out_data=0, out_valid=0, busy=0, done=0, and all internal counters 0.
- Reset mid-operation: reset has priority over every other input. Any transfer in progress is abandoned and no done pulse is produced.
- State IDLE: start=1 with word_count!=0 latches addr=base_addr and remaining=word_count, then goes to READ. start=1 with word_count==0 goes to DONE without touching memory.
- State READ (1 cycle): mem_rden=1 and mem_addr=addr, both registered. Loads wait_cnt=READ_LATENCY-1 and goes to WAIT.
- State WAIT: mem_rden=0 and mem_addr holds. When wait_cnt==0, captures mem_q into out_data, sets out_valid=1 and goes to PRESENT; otherwise decrements wait_cnt.
- State PRESENT: out_valid and out_data are held stable until out_valid&&out_ready. On that handshake out_valid drops to 0 and remaining decrements.
  - If remaining==1 (last word), go to DONE.
  - Otherwise addr=addr+1 (wrapping 2^ADDR_W-1 -> 0) and go to READ.
- State DONE (1 cycle): done=1, busy=0 on the following cycle, return to IDLE.
- Latency, with start sampled at edge E0:
  - mem_rden is high during E0..E1.
  - For READ_LATENCY=1, out_valid rises at E2.
  - With out_ready held high, throughput is one word per READ_LATENCY+2 cycles.
  - done is asserted for one cycle, starting at the edge after the last handshake.
- Backpressure: there is no limit on stall length, and out_data must not change while out_valid=1.
- Bus rule: the block never asserts mem_rden outside READ, so another master (e.g. the loader) can share the port while busy=0.
- start while busy: ignored, with no effect on the latched parameters.
- word_count=2^ADDR_W reads the whole memory once, ending at the address just before base_addr.

Decomposition:
- A shared package holds:
  - the state encoding constants (IDLE, READ, WAIT, PRESENT, DONE);
  - the default DATA_W=16 and ADDR_W=9 constants, shared with the loader and the memory_ip wrapper.
- No sub-module; a single FSM with address, remaining and wait counters.

Test Plan:
- Basic read: preload mem[5..8]={16'h0011,16'h0022,16'h0033,16'h0044}; start with base=5, count=4, out_ready=1 -> exactly 4 beats, 0011,0022,0033,0044 in order, done pulses once, mem_rden seen 4 times at addresses 5,6,7,8.
- Backpressure: same block with out_ready low for 7 cycles on beat 2 -> out_data holds 0022 with out_valid=1 throughout the stall, no extra mem_rden, order preserved.
- Wrap-around: base=9'd510, count=4 -> addresses 510, 511, 0, 1 and data matching those locations.
- Zero count: start with count=0 -> no mem_rden, no out_valid, done pulses on the cycle after DONE is entered, busy high for 1 cycle.
- Reset mid-operation: assert reset while in PRESENT on word 2 of 4 -> next cycle all outputs 0 and state IDLE, no done. A new start with base=0, count=1 then runs normally.
- Ignored start and latency: pulse start with base=100 during an active run -> no effect on the run. Repeat the basic read with READ_LATENCY=2 -> out_valid first rises at E3 and data is correct.
